// File: rtl/hpdmc_fml_arb.sv
// ---------------------------------------------------------------------------
// hpdmc_fml_arb
//
// Round-robin arbiter sharing the single FML port of the HPDMC DDR SDRAM
// controller among up to four masters (VGA refill, CPU cache, DMA, ...).
// A grant is locked for a complete burst: the address phase (s_stb high
// until the controller acks) plus data_hold cycles of data phase, during
// which write data and byte selects keep coming from the granted master.
//
// Optional build macro:
//   FML_ARB_PRIO_EN  - master 0 has fixed highest priority when it requests;
//                      the other masters stay round-robin among themselves.
//                      Undefined: pure round-robin.
//
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   m_adr/m_stb/m_we  packed master address, strobe and write enable
//   m_sel/m_di        packed master byte selects and write data
//   m_ack             per-master ack (only the owner sees s_ack)
//   m_do              read data broadcast to all masters
//   s_adr/s_stb/s_we  request towards the controller
//   s_sel/s_di        byte selects and write data towards the controller
//   s_ack/s_do        controller ack and read data
//   owner             index of the current or last granted master
// ---------------------------------------------------------------------------
module hpdmc_fml_arb #(
    parameter int nports      = 4,
    parameter int sdram_depth = 26,
    parameter int fml_width   = 64,
    parameter int data_hold   = 4
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,

    input  logic [nports*sdram_depth-1:0]     m_adr,
    input  logic [nports-1:0]                 m_stb,
    input  logic [nports-1:0]                 m_we,
    input  logic [nports*(fml_width/8)-1:0]   m_sel,
    input  logic [nports*fml_width-1:0]       m_di,
    output logic [nports-1:0]                 m_ack,
    output logic [fml_width-1:0]              m_do,

    output logic [sdram_depth-1:0]            s_adr,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [fml_width/8-1:0]            s_sel,
    output logic [fml_width-1:0]              s_di,
    input  logic                              s_ack,
    input  logic [fml_width-1:0]              s_do,

    output logic [1:0]                        owner
);

    localparam int SelW = fml_width / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [1:0]  r_owner;
    logic [1:0]  w_ownerNext;
    logic [3:0]  r_holdCnt;
    logic [3:0]  w_holdCntNext;

    // Scan the requesters starting just after the last owner, wrapping
    // modulo nports, so the last-served master has lowest priority.
    function automatic logic [1:0] pickNext(input logic [nports-1:0] stb,
                                            input logic [1:0]        last);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= nports; k++) begin
            idx = (int'(last) + k) % nports;
            if (!found && stb[idx]) begin
                pick  = 2'(idx);
                found = 1'b1;
            end
        end
`ifdef FML_ARB_PRIO_EN
        // Display refill must never underrun, so master 0 overrides.
        if (stb[0]) begin
            pick = 2'd0;
        end
`endif
        return pick;
    endfunction

    // State, owner and hold counter registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= IDLE;
            r_owner   <= 2'(nports - 1);
            r_holdCnt <= 4'd0;
        end else begin
            r_state   <= w_stateNext;
            r_owner   <= w_ownerNext;
            r_holdCnt <= w_holdCntNext;
        end
    end

    // Next-state logic. The owner is only updated when leaving IDLE, so it
    // stays stable through ADDR and DATA and the data steering follows it.
    always_comb begin
        w_stateNext   = r_state;
        w_ownerNext   = r_owner;
        w_holdCntNext = r_holdCnt;
        case (r_state)
            IDLE: begin
                if (|m_stb) begin
                    w_ownerNext = pickNext(m_stb, r_owner);
                    w_stateNext = ADDR;
                end
            end
            ADDR: begin
                // A dropped strobe here is a master protocol error; we keep
                // waiting for the controller rather than abandon its command.
                if (s_ack) begin
                    w_holdCntNext = 4'(data_hold);
                    w_stateNext   = DATA;
                end
            end
            DATA: begin
                w_holdCntNext = r_holdCnt - 4'd1;
                if (r_holdCnt == 4'd1) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Steer the owner's address, write enable, selects and data to the
    // controller; ack is routed only to the owner during the address phase.
    always_comb begin
        s_adr = '0;
        s_we  = 1'b0;
        s_sel = '0;
        s_di  = '0;
        m_ack = '0;
        for (int i = 0; i < nports; i++) begin
            if (r_owner == 2'(i)) begin
                s_adr    = m_adr[i*sdram_depth +: sdram_depth];
                s_we     = m_we[i];
                s_sel    = m_sel[i*SelW +: SelW];
                s_di     = m_di[i*fml_width +: fml_width];
                m_ack[i] = (r_state == ADDR) && s_ack;
            end
        end
    end

    assign s_stb = (r_state == ADDR);
    assign m_do  = s_do;
    assign owner = r_owner;

endmodule

// File: tb/tb_hpdmc_fml_arb.sv
// ---------------------------------------------------------------------------
// tb_hpdmc_fml_arb
//
// Self-checking bench for hpdmc_fml_arb. Each scenario task pushes the
// grants it expects onto a scoreboard queue; a monitor pops one entry per
// controller ack and compares owner, address, write enable and m_ack.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge or shortly after the inputs settle.
// ---------------------------------------------------------------------------
module tb_hpdmc_fml_arb;

    localparam int NPorts = 4;
    localparam int Depth  = 26;
    localparam int Width  = 64;
    localparam int SelW   = Width / 8;
    localparam int Hold   = 4;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst;
    logic [NPorts*Depth-1:0]   m_adr;
    logic [NPorts-1:0]         m_stb;
    logic [NPorts-1:0]         m_we;
    logic [NPorts*SelW-1:0]    m_sel;
    logic [NPorts*Width-1:0]   m_di;
    logic [NPorts-1:0]         m_ack;
    logic [Width-1:0]          m_do;
    logic [Depth-1:0]          s_adr;
    logic                      s_stb;
    logic                      s_we;
    logic [SelW-1:0]           s_sel;
    logic [Width-1:0]          s_di;
    logic                      s_ack;
    logic [Width-1:0]          s_do;
    logic [1:0]                owner;

    typedef struct {
        logic [1:0]       owner;
        logic [Depth-1:0] adr;
        logic             we;
    } exp_t;

    exp_t sbQ[$];
    exp_t monExp;
    int   checks   = 0;
    int   failures = 0;
    int   cycleNo  = 0;

    always #5 sys_clk = ~sys_clk;

    hpdmc_fml_arb #(
        .nports      (NPorts),
        .sdram_depth (Depth),
        .fml_width   (Width),
        .data_hold   (Hold)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .m_adr   (m_adr),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_di    (m_di),
        .m_ack   (m_ack),
        .m_do    (m_do),
        .s_adr   (s_adr),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_sel   (s_sel),
        .s_di    (s_di),
        .s_ack   (s_ack),
        .s_do    (s_do),
        .owner   (owner)
    );

    // Scoreboard consumer: every acked request must match the next expected
    // grant; outside an ack cycle no master may see an ack.
    always @(negedge sys_clk) begin
        if (!sys_rst && s_stb === 1'b1 && s_ack === 1'b1) begin
            checks++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL grant_unexpected owner=%0d adr=%h, required no grant",
                         owner, s_adr);
            end else begin
                monExp = sbQ.pop_front();
                if (owner !== monExp.owner || s_adr !== monExp.adr ||
                    s_we !== monExp.we || m_ack !== (4'b0001 << monExp.owner)) begin
                    failures++;
                    $display("[TB] FAIL grant owner=%0d adr=%h we=%b ack=%b, required owner=%0d adr=%h we=%b ack=%b",
                             owner, s_adr, s_we, m_ack, monExp.owner, monExp.adr,
                             monExp.we, 4'b0001 << monExp.owner);
                end
            end
        end else begin
            checks++;
            if (m_ack !== '0) begin
                failures++;
                $display("[TB] FAIL stray_ack m_ack=%b, required 0000", m_ack);
            end
        end
    end

    task automatic cycle();
        @(posedge sys_clk);
        #1;
        cycleNo++;
    endtask

    task automatic setMaster(input int i, input logic [Depth-1:0] adr,
                             input logic we, input logic [SelW-1:0] sel,
                             input logic [Width-1:0] di);
        m_adr[i*Depth +: Depth] = adr;
        m_we[i]                 = we;
        m_sel[i*SelW +: SelW]   = sel;
        m_di[i*Width +: Width]  = di;
    endtask

    task automatic pushExp(input logic [1:0] o, input logic [Depth-1:0] adr,
                           input logic we);
        exp_t e;
        e.owner = o;
        e.adr   = adr;
        e.we    = we;
        sbQ.push_back(e);
    endtask

    task automatic applyReset();
        sys_rst = 1'b1;
        m_stb   = '0;
        s_ack   = 1'b0;
        cycle();
        cycle();
        sys_rst = 1'b0;
        cycle();
    endtask

    task automatic waitStb(output bit ok);
        for (int k = 0; k < 64 && s_stb !== 1'b1; k++) begin
            cycle();
        end
        ok = (s_stb === 1'b1);
    endtask

    // Controller model: wait for a strobe, stall for delay cycles, ack once.
    task automatic serve(input int delay, output int ackCyc);
        bit ok;
        waitStb(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL stb_timeout s_stb=%b, required 1 within 64 cycles", s_stb);
            ackCyc = cycleNo;
        end else begin
            repeat (delay) cycle();
            s_ack  = 1'b1;
            ackCyc = cycleNo;
            cycle();
            s_ack  = 1'b0;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        m_stb   = '1;
        cycle();
        cycle();
        checks++;
        if (s_stb !== 1'b0 || m_ack !== '0 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL reset_state s_stb=%b m_ack=%b owner=%0d, required 0 0000 3",
                     s_stb, m_ack, owner);
        end
        m_stb   = '0;
        sys_rst = 1'b0;
        cycle();
    endtask

    task automatic test_single_master();
        int ack0, ack1;
        setMaster(1, 26'h100, 1'b0, 8'hFF, 64'h0);
        m_stb = 4'b0010;
        pushExp(2'd1, 26'h100, 1'b0);
        pushExp(2'd1, 26'h100, 1'b0);
        serve(3, ack0);
        for (int k = 0; k < Hold + 1; k++) begin
            checks++;
            if (s_stb !== 1'b0) begin
                failures++;
                $display("[TB] FAIL single_hold k=%0d s_stb=%b, required 0", k, s_stb);
            end
            cycle();
        end
        checks++;
        if (s_stb !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_regrant s_stb=%b, required 1", s_stb);
        end
        serve(0, ack1);
        m_stb = '0;
        checks++;
        if (ack1 - ack0 != Hold + 2) begin
            failures++;
            $display("[TB] FAIL single_spacing gap=%0d, required %0d", ack1 - ack0, Hold + 2);
        end
        repeat (Hold + 2) cycle();
    endtask

    task automatic test_contention();
        int a, prev;
        applyReset();
        for (int i = 0; i < NPorts; i++) begin
            setMaster(i, 26'h1000 + 26'(i), i[0], 8'hFF, 64'h0);
        end
        m_stb = 4'b1111;
        pushExp(2'd0, 26'h1000, 1'b0);
        pushExp(2'd1, 26'h1001, 1'b1);
        pushExp(2'd2, 26'h1002, 1'b0);
        pushExp(2'd3, 26'h1003, 1'b1);
        pushExp(2'd0, 26'h1000, 1'b0);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            serve(0, a);
            if (k > 0) begin
                checks++;
                if (a - prev != Hold + 2) begin
                    failures++;
                    $display("[TB] FAIL contention_spacing k=%0d gap=%0d, required %0d",
                             k, a - prev, Hold + 2);
                end
            end
            prev = a;
        end
        m_stb = '0;
        repeat (Hold + 2) cycle();
    endtask

    task automatic test_write_steering();
        bit ok;
        setMaster(2, 26'h2200, 1'b1, 8'h5A, 64'hA);
        setMaster(1, 26'h1100, 1'b0, 8'hFF, 64'h1111);
        m_stb = 4'b0100;
        pushExp(2'd2, 26'h2200, 1'b1);
        waitStb(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL write_stb_timeout s_stb=%b, required 1", s_stb);
        end
        s_ack = 1'b1;
        #1;
        checks++;
        if (s_di !== 64'hA || s_sel !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL write_beat0 s_di=%h s_sel=%h, required a 5a", s_di, s_sel);
        end
        cycle();
        s_ack = 1'b0;
        m_stb = '0;
        for (int b = 1; b < 4; b++) begin
            m_di[2*Width +: Width] = 64'hA + 64'(b);
            m_di[1*Width +: Width] = {$urandom, $urandom};
            #1;
            checks++;
            if (s_di !== 64'hA + 64'(b) || s_sel !== 8'h5A) begin
                failures++;
                $display("[TB] FAIL write_beat%0d s_di=%h s_sel=%h, required %h 5a",
                         b, s_di, s_sel, 64'hA + 64'(b));
            end
            cycle();
        end
        repeat (Hold + 2) cycle();
    endtask

    task automatic test_lock();
        int a;
        setMaster(1, 26'h0AB, 1'b0, 8'hFF, 64'h0);
        setMaster(3, 26'h3CD, 1'b1, 8'h0F, 64'h0);
        m_stb = 4'b0010;
        pushExp(2'd1, 26'h0AB, 1'b0);
        pushExp(2'd3, 26'h3CD, 1'b1);
        serve(0, a);
        m_stb = 4'b1000;
        for (int k = 0; k < Hold + 1; k++) begin
            checks++;
            if (s_stb !== 1'b0 || owner !== 2'd1) begin
                failures++;
                $display("[TB] FAIL lock_hold k=%0d s_stb=%b owner=%0d, required 0 1",
                         k, s_stb, owner);
            end
            cycle();
        end
        checks++;
        if (s_stb !== 1'b1 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL lock_next s_stb=%b owner=%0d, required 1 3", s_stb, owner);
        end
        serve(0, a);
        m_stb = '0;
        repeat (Hold + 2) cycle();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int a;
        setMaster(0, 26'h0C0, 1'b0, 8'hFF, 64'h0);
        setMaster(2, 26'h2200, 1'b1, 8'h5A, 64'h0);
        m_stb = 4'b0100;
        waitStb(ok);
        cycle();
        sys_rst = 1'b1;
        cycle();
        checks++;
        if (s_stb !== 1'b0 || m_ack !== '0 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL midburst_reset s_stb=%b m_ack=%b owner=%0d, required 0 0000 3",
                     s_stb, m_ack, owner);
        end
        sys_rst = 1'b0;
        m_stb   = 4'b0101;
        pushExp(2'd0, 26'h0C0, 1'b0);
        serve(0, a);
        m_stb = '0;
        repeat (Hold + 2) cycle();
    endtask

    task automatic test_back_to_back();
        int a, prev;
        applyReset();
        setMaster(0, 26'h0C0, 1'b0, 8'hFF, 64'h0);
        setMaster(2, 26'h2200, 1'b1, 8'h5A, 64'h0);
        m_stb = 4'b0101;
`ifdef FML_ARB_PRIO_EN
        pushExp(2'd0, 26'h0C0, 1'b0);
        pushExp(2'd0, 26'h0C0, 1'b0);
        pushExp(2'd0, 26'h0C0, 1'b0);
        pushExp(2'd0, 26'h0C0, 1'b0);
`else
        pushExp(2'd0, 26'h0C0, 1'b0);
        pushExp(2'd2, 26'h2200, 1'b1);
        pushExp(2'd0, 26'h0C0, 1'b0);
        pushExp(2'd2, 26'h2200, 1'b1);
`endif
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            serve(0, a);
            if (k > 0) begin
                checks++;
                if (a - prev != Hold + 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_spacing k=%0d gap=%0d, required %0d",
                             k, a - prev, Hold + 2);
                end
            end
            prev = a;
        end
        m_stb = '0;
        repeat (Hold + 2) cycle();
    endtask

    initial begin
        sys_rst = 1'b1;
        m_adr   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_sel   = '0;
        m_di    = '0;
        s_ack   = 1'b0;
        s_do    = 64'hDEAD_BEEF_0000_0001;
        test_reset();
        test_single_master();
        test_contention();
        test_write_steering();
        test_lock();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (4) cycle();
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain pending=%0d, required 0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout time=%0t, required completion before 200000", $time);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
